// File: rtl/load_store_unit.sv
// Load/store unit: turns a computed effective address plus RISC-V size/sign info
// into one req/ready data-memory transaction, with alignment, size and timeout faults.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? {CW{1'b0}} : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, FINISH = 2'b10} state_t;

  state_t        state_r, state_s;
  logic [2:0]    funct3_r, funct3_s;
  logic [1:0]    off_r, off_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          busy_s, done_s, mem_req_s, mem_we_s;
  logic [1:0]    fault_s;
  logic [31:0]   load_data_s, mem_addr_s, mem_wdata_s;
  logic [3:0]    mem_wstrb_s;
  logic          illegal_s, misaligned_s;
  logic [3:0]    strobe_s;
  logic [31:0]   wdata_s;

  // Select the addressed lane and sign/zero-extend it according to funct3.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = rdata;
      3'b100:  res_v = {24'h000000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  // Decode the live request inputs: legality, alignment, strobes and replicated data.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    strobe_s     = 4'b0000;
    wdata_s      = 32'h0000_0000;
    case (funct3)
      3'b000: begin
        strobe_s = 4'b0001 << address[1:0];
        wdata_s  = {4{store_data[7:0]}};
      end
      3'b001: begin
        strobe_s     = 4'b0011 << address[1:0];
        wdata_s      = {2{store_data[15:0]}};
        misaligned_s = address[0];
      end
      3'b010: begin
        strobe_s     = 4'b1111;
        wdata_s      = store_data;
        misaligned_s = (address[1:0] != 2'b00);
      end
      3'b100:  illegal_s = is_store;
      3'b101: begin
        illegal_s    = is_store;
        misaligned_s = address[0];
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    funct3_s    = funct3_r;
    off_s       = off_r;
    cnt_s       = cnt_r;
    busy_s      = busy;
    done_s      = 1'b0;
    fault_s     = 2'b00;
    load_data_s = load_data;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wstrb_s = mem_wstrb;
    mem_wdata_s = mem_wdata;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          busy_s   = 1'b1;
          funct3_s = funct3;
          off_s    = address[1:0];
          cnt_s    = {CW{1'b0}};
          if (illegal_s) begin
            state_s = FINISH;
            done_s  = 1'b1;
            fault_s = 2'b10;
          end else if (misaligned_s) begin
            state_s = FINISH;
            done_s  = 1'b1;
            fault_s = 2'b01;
          end else begin
            state_s     = ACCESS;
            mem_req_s   = 1'b1;
            mem_we_s    = is_store;
            mem_addr_s  = {address[31:2], 2'b00};
            mem_wstrb_s = is_store ? strobe_s : 4'b0000;
            mem_wdata_s = is_store ? wdata_s : 32'h0000_0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // A ready on the would-be timeout edge still completes normally.
        if (mem_ready) begin
          state_s     = FINISH;
          done_s      = 1'b1;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_addr_s  = 32'h0000_0000;
          mem_wstrb_s = 4'b0000;
          mem_wdata_s = 32'h0000_0000;
          if (!mem_we) begin
            load_data_s = extract_load(funct3_r, off_r, mem_rdata);
          end else begin
            load_data_s = load_data;
          end
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
          state_s     = FINISH;
          done_s      = 1'b1;
          fault_s     = 2'b11;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_addr_s  = 32'h0000_0000;
          mem_wstrb_s = 4'b0000;
          mem_wdata_s = 32'h0000_0000;
        end else begin
          cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      FINISH: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        cnt_s   = {CW{1'b0}};
      end
      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        cnt_s       = {CW{1'b0}};
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_wstrb_s = 4'b0000;
      end
    endcase
  end

  // State, captured operation info and all output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      funct3_r  <= 3'b000;
      off_r     <= 2'b00;
      cnt_r     <= {CW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 2'b00;
      load_data <= 32'h0000_0000;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      funct3_r  <= funct3_s;
      off_r     <= off_s;
      cnt_r     <= cnt_s;
      busy      <= busy_s;
      done      <= done_s;
      fault     <= fault_s;
      load_data <= load_data_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wstrb <= mem_wstrb_s;
      mem_wdata <= mem_wdata_s;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Consumer of the effective address produced by the address adder: takes a completed address plus operation info and performs one data-memory transaction on a simple req/ready bus.
- Stores: generates byte strobes and lane-replicated write data.
- Loads: extracts the addressed byte/half/word and sign- or zero-extends it.
- Flags misaligned accesses, illegal sizes and bus timeouts. The control unit stalls on `busy`.

Parameters:
- TIMEOUT, 16, number of cycles with mem_req high and no mem_ready before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load (captured at start)
- funct3  in  3  RISC-V size/sign field (captured at start)
- address  in  32  effective byte address (captured at start)
- store_data  in  32  rs2 value (captured at start)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse (success or fault)
- fault  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid while done=1, otherwise 00
- load_data  out  32  extended load result; updated only on successful load completion, then held
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  32  word address = {addr[31:2], 2'b00}
- mem_wstrb  out  4  byte strobes (0000 for loads)
- mem_wdata  out  32  write data
- mem_ready  in  1  bus accept/complete, sampled while mem_req=1
- mem_rdata  in  32  read data, valid on the mem_ready cycle

Behaviour:
- Reset (async):
  - state=IDLE, timeout counter=0.
  - All outputs 0: busy, done, fault, load_data, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata.
  - An operation in flight is abandoned, with no done pulse.
- States: IDLE, ACCESS, FINISH. All outputs are registered.
- IDLE, start=1 at an edge: capture inputs, then decode.
  - Legal funct3:
    - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores: 000 SB, 001 SH, 010 SW.
    - Anything else is illegal → FINISH, fault=10.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠00 → FINISH, fault=01. Illegal takes priority over misaligned.
  - Otherwise → ACCESS. mem_req=1 and mem_addr/mem_we/mem_wstrb/mem_wdata are driven from the next cycle.
- start while busy: ignored. start in FINISH is also ignored.
- Store strobes and data (off = addr[1:0]):
  - SB: wstrb = 0001<<off, wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011<<off, wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
- ACCESS: bus signals are held stable until an edge samples mem_ready=1.
  - Load: load_data ← extracted lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Then → FINISH with fault=00. mem_req falls in the same cycle done rises.
- Timeout:
  - The counter increments each ACCESS edge with mem_ready=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with mem_ready still 0 → FINISH, fault=11, mem_req dropped, load_data unchanged.
  - mem_ready=1 on that same edge wins, giving normal completion.
- FINISH: done=1 for exactly one cycle, busy=1, then → IDLE. The counter clears.
- Latency:
  - Successful op: start edge E0 → mem_req high after E0. If mem_ready=1 at E1, done is high in the cycle after E1. Minimum 2 edges start→done.
  - Fault (01/10): done in the cycle after E0 with no bus activity.
- Throughput: a new start is accepted at the edge ending the done cycle's successor. busy drops with done; the next start is sampled the cycle after FINISH.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- LW at 0x0000_1004, mem_ready at the first request cycle, rdata=0xDEAD_BEEF → mem_addr=0x1004, wstrb=0000, done 2 edges after start, load_data=0xDEAD_BEEF, fault=00.
- LB/LBU at 0x1003, rdata=0x80xx_xxxx → LB load_data=0xFFFF_FF80; LBU load_data=0x0000_0080. LH at 0x1002 with rdata=0x8001_xxxx → 0xFFFF_8001.
- SB at 0x2001, data=0x1234_56AB → wstrb=0010, wdata=0xABAB_ABAB, mem_we=1. SH at 0x2002, data=0x0000_CAFE → wstrb=1100, wdata=0xCAFE_CAFE.
- LH at 0x3001 → fault=01 with no mem_req. funct3=011 → fault=10. Store funct3=100 → fault=10. Each gives a single done pulse.
- TIMEOUT=16 with mem_ready held 0 → mem_req high for 16 cycles, then done with fault=11 and load_data unchanged. A second run with mem_ready on the 16th edge completes normally.
- Assert reset mid-ACCESS → mem_req/busy drop immediately with no done. A start asserted during busy is ignored, and a subsequent start after IDLE is accepted.
